// File: rtl/vpu_issue_pkg.sv
// Shared definitions for the VPU issue scheduler: FSM state encoding,
// default parameter values and an index-width helper.
package vpu_issue_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_OP_WIDTH   = 2;
   localparam int DEF_TAG_WIDTH  = 8;
   localparam int DEF_CNTR_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } sched_state_e;

   // A single requester still needs a one-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Combinational round-robin selector: the first asserted request at or
// above ptr_i (wrapping modulo NUM_REQ) wins.
module vpu_rr_arbiter
   import vpu_issue_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   int w_pos;

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      w_pos   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_pos = (int'(ptr_i) + k) % NUM_REQ;
         if (req_i[w_pos]) begin
            grant_o        = '0;
            grant_o[w_pos] = 1'b1;
            idx_o          = IDX_W'(w_pos);
            valid_o        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vpu_issue_sched.sv
// Single-slot issue scheduler: round-robin grant in IDLE, holds the issue
// until the datapath accepts, then enforces a per-opcode post-issue gap.
module vpu_issue_sched
   import vpu_issue_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int OP_WIDTH   = DEF_OP_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
   localparam int SRC_W     = idx_width(NUM_REQ),
   localparam int NUM_OPS   = 2 ** OP_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op_i,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_OPS*CNTR_WIDTH-1:0] lat_cfg_i,
   output logic                          issue_valid_o,
   output logic [OP_WIDTH-1:0]           issue_op_o,
   output logic [TAG_WIDTH-1:0]          issue_tag_o,
   output logic [SRC_W-1:0]              issue_src_o,
   input  logic                          issue_ready_i,
   output logic                          busy_o
);

   sched_state_e           r_state;
   logic [SRC_W-1:0]       r_rr_ptr;
   logic [CNTR_WIDTH-1:0]  r_gap_cnt;
   logic                   r_issue_valid;
   logic [OP_WIDTH-1:0]    r_op;
   logic [TAG_WIDTH-1:0]   r_tag;
   logic [SRC_W-1:0]       r_src;

   logic [OP_WIDTH-1:0]    w_req_op  [NUM_REQ];
   logic [TAG_WIDTH-1:0]   w_req_tag [NUM_REQ];
   logic [CNTR_WIDTH-1:0]  w_lat     [NUM_OPS];
   logic [NUM_REQ-1:0]     w_grant;
   logic [SRC_W-1:0]       w_gnt_idx;
   logic                   w_gnt_valid;
   logic                   w_idle;
   logic                   w_fire;
   logic                   w_hs;
   logic [CNTR_WIDTH-1:0]  w_load_lat;
   logic [SRC_W-1:0]       w_ptr_next;
   logic                   w_gap_last;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_unpack
         assign w_req_op[gi]  = req_op_i[gi*OP_WIDTH +: OP_WIDTH];
         assign w_req_tag[gi] = req_tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
      end
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_lat_unpack
         assign w_lat[gi] = lat_cfg_i[gi*CNTR_WIDTH +: CNTR_WIDTH];
      end
   endgenerate

   vpu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (SRC_W)
   ) u_arb (
      .req_i   (req_valid_i),
      .ptr_i   (r_rr_ptr),
      .grant_o (w_grant),
      .idx_o   (w_gnt_idx),
      .valid_o (w_gnt_valid)
   );

   assign w_idle      = (r_state == ST_IDLE);
   assign w_fire      = w_idle & w_gnt_valid;
   assign w_hs        = r_issue_valid & issue_ready_i;
   assign w_load_lat  = w_lat[r_op];
   assign w_ptr_next  = (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   // Leave GAP on the same edge the count reaches zero, so IDLE never sees a nonzero count.
   assign w_gap_last  = (r_gap_cnt == '0) || (r_gap_cnt == CNTR_WIDTH'(1));

   assign req_ready_o   = w_idle ? w_grant : '0;
   assign issue_valid_o = r_issue_valid;
   assign issue_op_o    = r_op;
   assign issue_tag_o   = r_tag;
   assign issue_src_o   = r_src;
   assign busy_o        = ~w_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap_cnt <= '0;
      end else if ((r_state == ST_HOLD) && w_hs) begin
         r_gap_cnt <= w_load_lat;
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
         r_gap_cnt <= r_gap_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_issue_valid <= 1'b0;
         r_op          <= '0;
         r_tag         <= '0;
         r_src         <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fire) begin
                  r_issue_valid <= 1'b1;
                  r_op          <= w_req_op[w_gnt_idx];
                  r_tag         <= w_req_tag[w_gnt_idx];
                  r_src         <= w_gnt_idx;
                  r_rr_ptr      <= w_ptr_next;
                  r_state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_hs) begin
                  r_issue_valid <= 1'b0;
                  r_state       <= (w_load_lat == '0) ? ST_IDLE : ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_gap_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_issue_valid <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vpu_issue_sched.sv
// Scoreboard bench for vpu_issue_sched: directed scenarios plus random
// traffic, all checked by a cycle-level behavioural monitor.
module tb_vpu_issue_sched;

   localparam int N    = 4;
   localparam int OPW  = 2;
   localparam int TAGW = 8;
   localparam int CW   = 4;
   localparam int NOPS = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [N-1:0]         req_valid_i = '0;
   logic [N*OPW-1:0]     req_op_i = '0;
   logic [N*TAGW-1:0]    req_tag_i = '0;
   logic [N-1:0]         req_ready_o;
   logic [NOPS*CW-1:0]   lat_cfg_i = '0;
   logic                 issue_valid_o;
   logic [OPW-1:0]       issue_op_o;
   logic [TAGW-1:0]      issue_tag_o;
   logic [1:0]           issue_src_o;
   logic                 issue_ready_i = 1'b0;
   logic                 busy_o;

   vpu_issue_sched #(
      .NUM_REQ    (N),
      .OP_WIDTH   (OPW),
      .TAG_WIDTH  (TAGW),
      .CNTR_WIDTH (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_op_i      (req_op_i),
      .req_tag_i     (req_tag_i),
      .req_ready_o   (req_ready_o),
      .lat_cfg_i     (lat_cfg_i),
      .issue_valid_o (issue_valid_o),
      .issue_op_o    (issue_op_o),
      .issue_tag_o   (issue_tag_o),
      .issue_src_o   (issue_src_o),
      .issue_ready_i (issue_ready_i),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int op;
      int tag;
      int src;
   } item_t;

   item_t sb_q[$];
   int    lat_m[NOPS];
   int    m_ptr = 0;
   int    m_free_at = 0;
   bit    m_pend = 0;
   int    gr_cyc[$];
   int    gr_src[$];
   int    hs_cyc[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Reference behaviour: one slot; a grant is due whenever the slot is empty
   // and the post-issue gap (1 + lat cycles after a handshake) has elapsed.
   always @(negedge clk) begin
      bit    free_now;
      bit    do_grant;
      int    e;
      item_t it;
      if (!rst_n) begin
         m_pend    = 0;
         m_free_at = 0;
         m_ptr     = 0;
         sb_q.delete();
      end else begin
         free_now = !m_pend && (cyc >= m_free_at);
         do_grant = 0;
         e        = -1;
         if (free_now) begin
            for (int k = N - 1; k >= 0; k--) begin
               if (req_valid_i[(m_ptr + k) % N]) e = (m_ptr + k) % N;
            end
         end
         if (e >= 0) begin
            chk("grant_vec", req_ready_o, longint'(1) << e);
            do_grant = 1;
         end else begin
            chk("ready_zero", req_ready_o, 0);
         end
         chk("issue_valid", issue_valid_o, m_pend);
         chk("busy", busy_o, (m_pend || cyc < m_free_at));
         if (m_pend && issue_valid_o) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 0, 1);
            end else begin
               chk("slot_op", issue_op_o, sb_q[0].op);
               chk("slot_tag", issue_tag_o, sb_q[0].tag);
               chk("slot_src", issue_src_o, sb_q[0].src);
               if (issue_ready_i) begin
                  it        = sb_q.pop_front();
                  m_free_at = cyc + 1 + lat_m[it.op];
                  m_pend    = 0;
                  hs_cyc.push_back(cyc);
                  $display("HS   cycle=%0d src=%0d op=%0d tag=%0d", cyc, it.src, it.op, it.tag);
               end
            end
         end
         if (do_grant) begin
            it.op  = int'(req_op_i[e*OPW +: OPW]);
            it.tag = int'(req_tag_i[e*TAGW +: TAGW]);
            it.src = e;
            sb_q.push_back(it);
            m_ptr  = (e + 1) % N;
            m_pend = 1;
            gr_cyc.push_back(cyc);
            gr_src.push_back(e);
         end
      end
   end

   task automatic clear_logs();
      gr_cyc.delete();
      gr_src.delete();
      hs_cyc.delete();
   endtask

   task automatic set_lat(input int a, input int b, input int c, input int d);
      lat_m[0] = a;
      lat_m[1] = b;
      lat_m[2] = c;
      lat_m[3] = d;
      lat_cfg_i = {CW'(d), CW'(c), CW'(b), CW'(a)};
   endtask

   task automatic set_req(input int i, input int op, input int tag);
      req_valid_i[i]               = 1'b1;
      req_op_i[i*OPW +: OPW]       = OPW'(op);
      req_tag_i[i*TAGW +: TAGW]    = TAGW'(tag);
   endtask

   task automatic do_reset();
      req_valid_i   = '0;
      issue_ready_i = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
   endtask

   // One cycle: observe grants, then re-tag (keep) or drop each granted requester.
   task automatic step(input logic [N-1:0] keep);
      logic [N-1:0] g;
      @(negedge clk);
      g = req_ready_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            if (keep[i]) req_tag_i[i*TAGW +: TAGW] = TAGW'($urandom_range(255));
            else req_valid_i[i] = 1'b0;
         end
      end
   endtask

   task automatic random_phase(input int ncyc);
      logic [N-1:0] g;
      do_reset();
      set_lat($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
      for (int t = 0; t < ncyc; t++) begin
         @(negedge clk);
         g = req_ready_o;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (g[i]) req_valid_i[i] = 1'b0;
            if (!req_valid_i[i]) begin
               if ($urandom_range(99) < 35) set_req(i, $urandom_range(3), $urandom_range(255));
            end else if ($urandom_range(99) < 3) begin
               req_valid_i[i] = 1'b0;
            end
         end
         issue_ready_i = ($urandom_range(99) < 65);
      end
      req_valid_i   = '0;
      issue_ready_i = 1'b1;
      for (int t = 0; t < 60 && (busy_o || issue_valid_o); t++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_sb_empty", sb_q.size(), 0);
      chk("drain_busy", busy_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int fall;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_issue_valid", issue_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_op", issue_op_o, 0);
      chk("rst_tag", issue_tag_o, 0);
      chk("rst_src", issue_src_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single requester, lat 3: valid one cycle after grant, handshakes 5 apart.
      do_reset();
      set_lat(0, 3, 0, 0);
      issue_ready_i = 1'b1;
      set_req(2, 1, 8'hA5);
      for (int t = 0; t < 30 && hs_cyc.size() < 2; t++) step(4'b0100);
      req_valid_i = '0;
      if (hs_cyc.size() >= 2) begin
         chk("t33_src", gr_src[0], 2);
         chk("t33_valid_lat", hs_cyc[0] - gr_cyc[0], 1);
         chk("t33_spacing", hs_cyc[1] - hs_cyc[0], 5);
      end else begin
         chk("t33_timeout", hs_cyc.size(), 2);
      end

      // All requesting, zero gap: grants 0,1,2,3,0 every second cycle.
      do_reset();
      set_lat(0, 0, 0, 0);
      issue_ready_i = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, i, 16 * i + 1);
      for (int t = 0; t < 40 && gr_cyc.size() < 5; t++) step(4'hF);
      req_valid_i = '0;
      if (gr_cyc.size() >= 5) begin
         for (int k = 0; k < 5; k++) chk("t34_order", gr_src[k], k % N);
         for (int k = 1; k < 5; k++) chk("t34_spacing", gr_cyc[k] - gr_cyc[k-1], 2);
      end else begin
         chk("t34_timeout", gr_cyc.size(), 5);
      end

      // Backpressure for 6 cycles, handshake on the 7th.
      do_reset();
      set_lat(0, 0, 0, 0);
      set_req(1, 2, 8'h3C);
      set_req(3, 1, 8'h77);
      for (int t = 0; t < 10 && gr_cyc.size() < 1; t++) step(4'b1000);
      repeat (6) step(4'b1000);
      issue_ready_i = 1'b1;
      for (int t = 0; t < 5 && hs_cyc.size() < 1; t++) step(4'b0000);
      req_valid_i = '0;
      if (hs_cyc.size() >= 1 && gr_cyc.size() >= 1) begin
         chk("t35_first_src", gr_src[0], 1);
         chk("t35_hold_len", hs_cyc[0] - gr_cyc[0], 7);
      end else begin
         chk("t35_timeout", hs_cyc.size(), 1);
      end

      // Maximum gap: busy for 15 cycles after the issue leaves, then IDLE held.
      do_reset();
      set_lat(15, 15, 15, 15);
      issue_ready_i = 1'b1;
      set_req(0, 2, 8'h11);
      for (int t = 0; t < 6 && hs_cyc.size() < 1; t++) step(4'b0000);
      if (hs_cyc.size() >= 1) begin
         fall = -1;
         for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!busy_o && fall < 0) fall = cyc;
         end
         chk("t36_gap_len", fall - hs_cyc[0], 16);
         chk("t36_idle_busy", busy_o, 0);
         chk("t36_idle_valid", issue_valid_o, 0);
         @(posedge clk);
         #1;
      end else begin
         chk("t36_timeout", hs_cyc.size(), 1);
      end

      // Asynchronous reset mid-HOLD, then round-robin restarts at requester 0.
      do_reset();
      set_lat(0, 0, 0, 0);
      set_req(2, 0, 8'hC3);
      for (int t = 0; t < 6 && gr_cyc.size() < 1; t++) step(4'b0000);
      chk("t37_in_hold", issue_valid_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t37_async_valid", issue_valid_o, 0);
      chk("t37_async_busy", busy_o, 0);
      chk("t37_async_tag", issue_tag_o, 0);
      chk("t37_async_src", issue_src_o, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
      for (int i = 0; i < N; i++) set_req(i, 1, 8'h50 + i);
      for (int t = 0; t < 6 && gr_cyc.size() < 1; t++) step(4'b0000);
      if (gr_cyc.size() >= 1) chk("t37_restart_src", gr_src[0], 0);
      else chk("t37_timeout", gr_cyc.size(), 1);
      req_valid_i   = '0;
      issue_ready_i = 1'b1;

      random_phase(800);
      random_phase(800);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
